// File: rtl/clause_vote_accumulator.sv
// Per-image clause vote accumulator: ORs clause outputs across patches, applies signed
// per-class weights serially with saturation, then argmaxes to a predicted class.
module clause_vote_accumulator #(
  parameter int unsigned NUM_CLAUSES = 32,
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WEIGHT_W    = 8,
  parameter int unsigned SUM_W       = 16,
  parameter int unsigned CLASS_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           ops_valid,
  input  logic [NUM_CLAUSES-1:0]         clause_ops,
  input  logic                           frame_end,
  input  logic                           w_wr_en,
  input  logic [CLASS_W-1:0]             w_class,
  input  logic [$clog2(NUM_CLAUSES)-1:0] w_clause,
  input  logic [WEIGHT_W-1:0]            w_data,
  output logic                           busy,
  output logic [NUM_CLAUSES-1:0]         clause_hit,
  output logic                           pred_valid,
  output logic [CLASS_W-1:0]             pred_class,
  output logic [SUM_W-1:0]               pred_sum
);

  localparam int unsigned ClauseW = $clog2(NUM_CLAUSES);

  typedef enum logic [2:0] {StIdle, StCollect, StSum, StArgmax, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ClauseW-1:0]       k_q, k_d;
  logic [CLASS_W-1:0]       c_q, c_d;
  logic [NUM_CLAUSES-1:0]   hit_q, hit_d;
  logic signed [SUM_W-1:0]  sum_q [NUM_CLASSES];
  logic signed [SUM_W-1:0]  sum_d [NUM_CLASSES];
  logic [WEIGHT_W-1:0]      w_q [NUM_CLASSES][NUM_CLAUSES];
  logic [WEIGHT_W-1:0]      w_d [NUM_CLASSES][NUM_CLAUSES];
  logic [CLASS_W-1:0]       best_idx_q, best_idx_d;
  logic signed [SUM_W-1:0]  best_sum_q, best_sum_d;
  logic                     pred_valid_q, pred_valid_d;
  logic [CLASS_W-1:0]       pred_class_q, pred_class_d;
  logic [SUM_W-1:0]         pred_sum_q, pred_sum_d;
  logic                     busy_q, busy_d;

  // One extra bit of headroom: overflow shows up as disagreement of the top two bits.
  function automatic logic signed [SUM_W-1:0] sat_add(input logic signed [SUM_W-1:0] a,
                                                      input logic [WEIGHT_W-1:0] w);
    logic signed [SUM_W:0] r;
    r = {a[SUM_W-1], a} + {{(SUM_W + 1 - WEIGHT_W){w[WEIGHT_W-1]}}, w};
    if (r[SUM_W] != r[SUM_W-1]) begin
      sat_add = r[SUM_W] ? {1'b1, {(SUM_W - 1){1'b0}}} : {1'b0, {(SUM_W - 1){1'b1}}};
    end else begin
      sat_add = r[SUM_W-1:0];
    end
  endfunction

  always_comb begin
    w_d = w_q;
    if (w_wr_en && (state_q == StIdle) &&
        ({1'b0, w_class} < (CLASS_W + 1)'(NUM_CLASSES))) begin
      w_d[w_class][w_clause] = w_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    hit_d        = hit_q;
    sum_d        = sum_q;
    best_idx_d   = best_idx_q;
    best_sum_d   = best_sum_q;
    pred_valid_d = 1'b0;
    pred_class_d = pred_class_q;
    pred_sum_d   = pred_sum_q;
    case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d = StCollect;
          hit_d   = '0;
          for (int c = 0; c < NUM_CLASSES; c++) sum_d[c] = '0;
        end
      end
      StCollect: begin
        if (frame_start) begin
          hit_d = '0;
        end else begin
          if (ops_valid) hit_d = hit_q | clause_ops;
          if (frame_end) begin
            state_d = StSum;
            k_d     = '0;
          end
        end
      end
      StSum: begin
        if (hit_q[k_q]) begin
          for (int c = 0; c < NUM_CLASSES; c++) sum_d[c] = sat_add(sum_q[c], w_q[c][k_q]);
        end
        k_d = k_q + 1'b1;
        if (k_q == ClauseW'(NUM_CLAUSES - 1)) begin
          state_d = StArgmax;
          c_d     = '0;
        end
      end
      StArgmax: begin
        // Strictly-greater replacement keeps the lowest index on ties.
        if ((c_q == '0) || (sum_q[c_q] > best_sum_q)) begin
          best_idx_d = c_q;
          best_sum_d = sum_q[c_q];
        end
        c_d = c_q + 1'b1;
        if (c_q == CLASS_W'(NUM_CLASSES - 1)) state_d = StDone;
      end
      StDone: begin
        pred_valid_d = 1'b1;
        pred_class_d = best_idx_q;
        pred_sum_d   = best_sum_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Busy covers the result pulse so it drops only once the prediction has been presented.
    busy_d = (state_d != StIdle) || pred_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      c_q          <= '0;
      hit_q        <= '0;
      sum_q        <= '{default: '0};
      w_q          <= '{default: '0};
      best_idx_q   <= '0;
      best_sum_q   <= '0;
      pred_valid_q <= 1'b0;
      pred_class_q <= '0;
      pred_sum_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      c_q          <= c_d;
      hit_q        <= hit_d;
      sum_q        <= sum_d;
      w_q          <= w_d;
      best_idx_q   <= best_idx_d;
      best_sum_q   <= best_sum_d;
      pred_valid_q <= pred_valid_d;
      pred_class_q <= pred_class_d;
      pred_sum_q   <= pred_sum_d;
      busy_q       <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign clause_hit = hit_q;
  assign pred_valid = pred_valid_q;
  assign pred_class = pred_class_q;
  assign pred_sum   = pred_sum_q;

endmodule

// File: tb/tb_clause_vote_accumulator.sv
// Bench for clause_vote_accumulator: 16-bit and 8-bit sum instances driven in lockstep and
// checked every cycle against a frame-level vote model.
module tb_clause_vote_accumulator;
  localparam int NCL = 32;
  localparam int NCS = 10;
  localparam int LAT = NCL + NCS + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0, ops_valid = 1'b0, frame_end = 1'b0, w_wr_en = 1'b0;
  logic [31:0] clause_ops = '0;
  logic [3:0]  w_class = '0;
  logic [4:0]  w_clause = '0;
  logic [7:0]  w_data = '0;

  logic        busy_a, pv_a, busy_b, pv_b;
  logic [31:0] hit_a, hit_b;
  logic [3:0]  cls_a, cls_b;
  logic [15:0] sum_a;
  logic [7:0]  sum_b;

  always #5 clk = ~clk;

  clause_vote_accumulator dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .ops_valid(ops_valid),
    .clause_ops(clause_ops), .frame_end(frame_end), .w_wr_en(w_wr_en), .w_class(w_class),
    .w_clause(w_clause), .w_data(w_data), .busy(busy_a), .clause_hit(hit_a),
    .pred_valid(pv_a), .pred_class(cls_a), .pred_sum(sum_a)
  );

  clause_vote_accumulator #(.SUM_W(8)) dut8 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .ops_valid(ops_valid),
    .clause_ops(clause_ops), .frame_end(frame_end), .w_wr_en(w_wr_en), .w_class(w_class),
    .w_clause(w_clause), .w_data(w_data), .busy(busy_b), .clause_hit(hit_b),
    .pred_valid(pv_b), .pred_class(cls_b), .pred_sum(sum_b)
  );

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Model state: weights, per-frame OR, and a phase/edge count instead of a cycle-level FSM.
  int          mw [NCS][NCL];
  logic [31:0] m_hit;
  int          phase;  // 0 idle, 1 collecting, 2 computing
  int          cnt;
  bit          m_pv;
  int          m_cls16, m_sum16, m_cls8, m_sum8;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp,
               $time);
    end
  endtask

  function automatic int msum(input logic [31:0] h, input int c, input int sw);
    int lo, hi, s;
    lo = -(1 << (sw - 1));
    hi = (1 << (sw - 1)) - 1;
    s = 0;
    for (int k = 0; k < NCL; k++) begin
      if (h[k]) begin
        s = s + mw[c][k];
        if (s > hi) s = hi;
        if (s < lo) s = lo;
      end
    end
    return s;
  endfunction

  task automatic predict(input logic [31:0] h, input int sw, output int cls, output int s);
    int v;
    cls = 0;
    s = msum(h, 0, sw);
    for (int c = 1; c < NCS; c++) begin
      v = msum(h, c, sw);
      if (v > s) begin
        s = v;
        cls = c;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < NCS; c++) for (int k = 0; k < NCL; k++) mw[c][k] = 0;
      m_hit = '0; phase = 0; cnt = 0; m_pv = 1'b0;
      m_cls16 = 0; m_sum16 = 0; m_cls8 = 0; m_sum8 = 0;
    end else begin
      m_pv = 1'b0;
      if (phase == 0) begin
        if (w_wr_en && (w_class < NCS)) mw[w_class][w_clause] = $signed(w_data);
        if (frame_start) begin
          phase = 1;
          m_hit = '0;
        end
      end else if (phase == 1) begin
        if (frame_start) begin
          m_hit = '0;
        end else begin
          if (ops_valid) m_hit = m_hit | clause_ops;
          if (frame_end) begin
            phase = 2;
            cnt = 0;
          end
        end
      end else begin
        cnt++;
        if (cnt == LAT) begin
          predict(m_hit, 16, m_cls16, m_sum16);
          predict(m_hit, 8, m_cls8, m_sum8);
          m_pv = 1'b1;
          phase = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (started && !rst) begin
      check("busy16", busy_a, int'((phase != 0) || m_pv));
      check("busy8", busy_b, int'((phase != 0) || m_pv));
      check("pred_valid16", pv_a, int'(m_pv));
      check("pred_valid8", pv_b, int'(m_pv));
      check("clause_hit16", hit_a, m_hit);
      check("clause_hit8", hit_b, m_hit);
      check("pred_class16", cls_a, m_cls16);
      check("pred_class8", cls_b, m_cls8);
      check("pred_sum16", $signed(sum_a), m_sum16);
      check("pred_sum8", $signed(sum_b), m_sum8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #3 rst = 1'b1;
    repeat (2) tick();
    #3 rst = 1'b0;
    tick();
  endtask

  task automatic wr(input int c, input int k, input int d);
    w_class = c[3:0]; w_clause = k[4:0]; w_data = d[7:0]; w_wr_en = 1'b1;
    tick();
    w_wr_en = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic beat(input bit v, input logic [31:0] ops);
    ops_valid = v; clause_ops = ops;
    tick();
    ops_valid = 1'b0;
  endtask

  task automatic fend(input bit v, input logic [31:0] ops);
    frame_end = 1'b1; ops_valid = v; clause_ops = ops;
    tick();
    frame_end = 1'b0; ops_valid = 1'b0;
  endtask

  // Counts edges after the frame_end edge; optionally injects a dropped weight write or an
  // ignored frame_start at chosen edge offsets.
  task automatic wait_pred(input int w_at, input int fs_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      w_wr_en = 1'b0;
      frame_start = 1'b0;
      if (pv_a) begin
        lat = n;
        break;
      end
      if (n == w_at) begin
        w_class = 4'd0; w_clause = 5'd5; w_data = 8'd100; w_wr_en = 1'b1;
      end
      if (n == fs_at) frame_start = 1'b1;
    end
    w_wr_en = 1'b0;
    frame_start = 1'b0;
    check("pred_latency", lat, LAT);
  endtask

  int lat, seen;

  initial begin
    do_reset();
    started = 1'b1;
    check("reset_busy", busy_a, 0);
    check("reset_hit", hit_a, 0);

    // Single-patch vote
    wr(3, 5, 7);
    fstart(); beat(1'b1, 32'h20); fend(1'b0, '0);
    wait_pred(-1, -1, lat);
    check("s1_class", cls_a, 3);
    check("s1_sum", $signed(sum_a), 7);
    check("s1_hit", hit_a, 32'h20);
    check("s1_sum8", $signed(sum_b), 7);

    // OR across patches
    do_reset();
    wr(2, 0, 3); wr(2, 1, 4); wr(7, 1, 6);
    fstart(); beat(1'b1, 32'h1); beat(1'b1, 32'h2); beat(1'b1, 32'h1); fend(1'b0, '0);
    wait_pred(-1, -1, lat);
    check("s2_hit", hit_a, 32'h3);
    check("s2_class", cls_a, 2);
    check("s2_sum", $signed(sum_a), 7);
    check("s2_model_c7", msum(32'h3, 7, 16), 6);
    check("s2_model_c2", msum(32'h3, 2, 16), 7);

    // Tie and negative sums
    do_reset();
    for (int c = 0; c < NCS; c++) wr(c, 0, (c == 4) ? -2 : ((c == 6 || c == 9) ? 5 : -1));
    fstart(); fend(1'b1, 32'h1);
    wait_pred(-1, -1, lat);
    check("s3_class", cls_a, 6);
    check("s3_sum", $signed(sum_a), 5);

    // Saturation
    do_reset();
    for (int k = 0; k < NCL; k++) wr(1, k, 127);
    fstart(); beat(1'b1, 32'hFFFF_FFFF); fend(1'b0, '0);
    wait_pred(-1, -1, lat);
    check("s4_sum8", $signed(sum_b), 127);
    check("s4_class8", cls_b, 1);
    check("s4_sum16", $signed(sum_a), 4064);
    check("s4_class16", cls_a, 1);

    // Ignored inputs: out-of-range class, write during SUM, frame_start during ARGMAX
    do_reset();
    wr(3, 5, 7);
    wr(12, 5, 50);
    fstart(); beat(1'b1, 32'h20); fend(1'b0, '0);
    wait_pred(5, 35, lat);
    check("s5_class", cls_a, 3);
    check("s5_sum", $signed(sum_a), 7);
    check("s5_busy_at_pred", busy_a, 1);
    tick();
    check("s5_busy_after", busy_a, 0);

    // Asynchronous reset mid-SUM
    fstart(); beat(1'b1, 32'h20); fend(1'b0, '0);
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    check("s6_busy", busy_a, 0);
    check("s6_hit", hit_a, 0);
    check("s6_pv", pv_a, 0);
    check("s6_busy8", busy_b, 0);
    #2 rst = 1'b0;
    seen = 0;
    repeat (60) begin
      tick();
      if (pv_a || pv_b) seen++;
    end
    check("s6_no_pred", seen, 0);
    fstart(); beat(1'b1, 32'h20); fend(1'b0, '0);
    wait_pred(-1, -1, lat);
    check("s6_sum_cleared", $signed(sum_a), 0);
    check("s6_class_cleared", cls_a, 0);

    // Empty frame
    fstart(); fend(1'b0, '0);
    wait_pred(-1, -1, lat);
    check("empty_hit", hit_a, 0);
    check("empty_class", cls_a, 0);

    // Randomized frames against the model
    do_reset();
    repeat (40) wr($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 255));
    for (int f = 0; f < 12; f++) begin
      fstart();
      for (int b = $urandom_range(0, 5); b > 0; b--) begin
        if ($urandom_range(0, 7) == 0) fstart();
        beat($urandom_range(0, 3) != 0, (f % 3 == 0) ? $urandom : ($urandom & $urandom));
      end
      fend($urandom_range(0, 1) == 1, $urandom & $urandom);
      wait_pred(($urandom_range(0, 1) == 1) ? $urandom_range(1, 42) : -1,
                ($urandom_range(0, 1) == 1) ? $urandom_range(1, 42) : -1, lat);
      tick();
      repeat ($urandom_range(0, 6))
        wr($urandom_range(0, 11), $urandom_range(0, 31), $urandom_range(0, 255));
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
